// File: rtl/freqdiv_ctrl.sv
// -----------------------------------------------------------------------------
// freqdiv_ctrl
//
// Purpose:
//   Owns a single freqdiv instance. Two requesters may ask for a new divide
//   ratio N. Access is granted round-robin. A new N is applied only on a rising
//   edge of the divider output, or after TIMEOUT cycles without one. The new N
//   is then followed by a reset pulse that lasts RST_CYCLES cycles.
//   A request whose N equals the current ratio completes at once and causes
//   no reset pulse.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   req0_valid   in   1   requester 0 offers a new ratio
//   req0_n       in   NW  ratio from requester 0
//   req0_ready   out  1   requester 0 is accepted this cycle (combinational)
//   req1_valid   in   1   requester 1 offers a new ratio
//   req1_n       in   NW  ratio from requester 1
//   req1_ready   out  1   requester 1 is accepted this cycle (combinational)
//   div_out      in   1   divider output, same clock domain
//   div_n        out  NW  ratio driven to the divider
//   div_reset    out  1   reset driven to the divider
//   busy         out  1   controller is not idle
//   done         out  1   one-cycle pulse when an accepted request completes
//   done_id      out  1   requester served by the completing request
//   timed_out    out  1   pulse with done when the edge wait hit TIMEOUT
// -----------------------------------------------------------------------------
module freqdiv_ctrl #(
    parameter int unsigned       NW         = 16,
    parameter logic [NW-1:0]     DEFAULT_N  = '0,
    parameter int unsigned       RST_CYCLES = 2,
    parameter int unsigned       TIMEOUT    = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [NW-1:0] req0_n,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [NW-1:0] req1_n,
    output logic          req1_ready,
    input  logic          div_out,
    output logic [NW-1:0] div_n,
    output logic          div_reset,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic          timed_out
);

    localparam int unsigned TW = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;
    localparam int unsigned HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] to_cnt;
    logic [HW-1:0] hold_cnt;
    logic [NW-1:0] n_q;
    logic          id_q;
    logic          to_q;        // the ALIGN exit was forced by the timeout
    logic          pending;     // HOLD belongs to a request, not to init reset
    logic          skip_q;      // done of an equal-N request is in flight
    logic          last_grant;
    logic          div_out_q;

    logic          idle_ok;
    logic          acc0;
    logic          acc1;
    logic          accept;
    logic          acc_id;
    logic [NW-1:0] acc_n;
    logic          rise;

    // Ready is offered to one requester at most. On a tie, the requester not
    // served last time wins. No request is accepted in the cycle in which an
    // equal-N request reports done.
    assign idle_ok    = (state == IDLE) && !skip_q;
    assign req0_ready = idle_ok && req0_valid && (!req1_valid ||  last_grant);
    assign req1_ready = idle_ok && req1_valid && (!req0_valid || !last_grant);

    assign acc0   = req0_valid && req0_ready;
    assign acc1   = req1_valid && req1_ready;
    assign accept = acc0 || acc1;
    assign acc_id = acc1;
    assign acc_n  = acc1 ? req1_n : req0_n;

    assign rise = div_out && !div_out_q;

    // NOTE: every register below is assigned non-blocking, so each branch reads
    // the values from the previous clock edge, whatever the statement order.
    // NOTE: this block holds only control registers. They all get a reset
    // value; no storage array exists that could be left unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            to_cnt     <= '0;
            hold_cnt   <= '0;
            n_q        <= '0;
            id_q       <= 1'b0;
            to_q       <= 1'b0;
            pending    <= 1'b0;
            skip_q     <= 1'b0;
            last_grant <= 1'b1;
            div_out_q  <= 1'b0;
            div_n      <= DEFAULT_N;
            div_reset  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            done_id    <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            div_out_q <= div_out;
            done      <= 1'b0;
            timed_out <= 1'b0;
            skip_q    <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        n_q        <= acc_n;
                        id_q       <= acc_id;
                        last_grant <= acc_id;
                        if (acc_n == div_n) begin
                            // The ratio is unchanged. Report done and leave
                            // the divider running.
                            done    <= 1'b1;
                            done_id <= acc_id;
                            skip_q  <= 1'b1;
                        end else begin
                            state   <= ALIGN;
                            busy    <= 1'b1;
                            to_cnt  <= '0;
                            pending <= 1'b1;
                        end
                    end
                end

                ALIGN: begin
                    if (rise || (to_cnt == TO_LAST)) begin
                        div_n     <= n_q;
                        div_reset <= 1'b1;
                        hold_cnt  <= '0;
                        to_q      <= !rise;
                        state     <= HOLD;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        div_reset <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                        // The init HOLD after reset completes no request, so
                        // it produces no done pulse.
                        done      <= pending;
                        done_id   <= id_q;
                        timed_out <= pending && to_q;
                        pending   <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= HOLD;
                    hold_cnt  <= '0;
                    div_reset <= 1'b1;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freqdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freqdiv_ctrl
//
// Directed bench for freqdiv_ctrl with NW=16, DEFAULT_N=0, RST_CYCLES=2 and
// TIMEOUT=10. Inputs change, and outputs are read, 2 time units after each
// rising clock edge. Expected values are worked out by hand from the
// controller's cycle behaviour.
// -----------------------------------------------------------------------------
module tb_freqdiv_ctrl;

    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid;
    logic [NW-1:0] req0_n;
    logic          req0_ready;
    logic          req1_valid;
    logic [NW-1:0] req1_n;
    logic          req1_ready;
    logic          div_out;
    logic [NW-1:0] div_n;
    logic          div_reset;
    logic          busy;
    logic          done;
    logic          done_id;
    logic          timed_out;

    int n_cmp  = 0;
    int n_fail = 0;

    freqdiv_ctrl #(
        .NW        (NW),
        .DEFAULT_N ('0),
        .RST_CYCLES(2),
        .TIMEOUT   (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_n    (req0_n),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_n    (req1_n),
        .req1_ready(req1_ready),
        .div_out   (div_out),
        .div_n     (div_n),
        .div_reset (div_reset),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .timed_out (timed_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0;
        req0_n     = '0;
        req1_valid = 1'b0;
        req1_n     = '0;
        div_out    = 1'b0;

        // Values while reset is held.
        step();
        step();
        check("rst_div_n",     32'(div_n),      32'h0);
        check("rst_div_reset", 32'(div_reset),  32'h1);
        check("rst_busy",      32'(busy),       32'h1);
        check("rst_done",      32'(done),       32'h0);
        check("rst_ready0",    32'(req0_ready), 32'h0);

        // 1: after release, div_reset stays high for 2 cycles, then IDLE.
        reset = 1'b0;
        step();
        check("t1_div_reset_c1", 32'(div_reset), 32'h1);
        check("t1_busy_c1",      32'(busy),      32'h1);
        check("t1_done_c1",      32'(done),      32'h0);
        step();
        check("t1_div_reset_c2", 32'(div_reset), 32'h0);
        check("t1_busy_c2",      32'(busy),      32'h0);
        check("t1_done_c2",      32'(done),      32'h0);
        check("t1_div_n",        32'(div_n),     32'h0);

        // 2: req0 asks for n=4. The div_out edge is present 3 cycles after accept.
        req0_valid = 1'b1;
        req0_n     = 16'd4;
        #1;
        check("t2_ready0", 32'(req0_ready), 32'h1);
        check("t2_ready1", 32'(req1_ready), 32'h0);
        step();                                   // accept
        req0_valid = 1'b0;
        req0_n     = '0;
        check("t2_busy",      32'(busy),      32'h1);
        check("t2_div_reset", 32'(div_reset), 32'h0);
        step();
        step();
        div_out = 1'b1;
        check("t2_div_n_before", 32'(div_n), 32'h0);
        step();                                   // edge seen
        check("t2_div_n",       32'(div_n),     32'h4);
        check("t2_div_reset_1", 32'(div_reset), 32'h1);
        step();
        check("t2_div_reset_2", 32'(div_reset), 32'h1);
        check("t2_done_early",  32'(done),      32'h0);
        step();
        check("t2_div_reset_off", 32'(div_reset), 32'h0);
        check("t2_done",          32'(done),      32'h1);
        check("t2_done_id",       32'(done_id),   32'h0);
        check("t2_timed_out",     32'(timed_out), 32'h0);
        check("t2_busy_off",      32'(busy),      32'h0);
        step();
        check("t2_done_pulse", 32'(done), 32'h0);
        div_out = 1'b0;

        // 3: reset first so last_grant starts at 1. Then a tie n=5 / n=10.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        check("t3_idle",    32'(busy),  32'h0);
        check("t3_div_n_0", 32'(div_n), 32'h0);
        req0_valid = 1'b1;
        req0_n     = 16'd5;
        req1_valid = 1'b1;
        req1_n     = 16'd10;
        #1;
        check("t3_tie_ready0", 32'(req0_ready), 32'h1);
        check("t3_tie_ready1", 32'(req1_ready), 32'h0);
        step();                                   // accept req0
        req0_valid = 1'b0;
        div_out    = 1'b1;
        #1;
        check("t3_busy_ready1", 32'(req1_ready), 32'h0);
        step();
        check("t3_div_n_5",    32'(div_n),     32'h5);
        check("t3_div_reset",  32'(div_reset), 32'h1);
        step();
        step();
        check("t3_done0",    32'(done),    32'h1);
        check("t3_done_id0", 32'(done_id), 32'h0);
        #1;
        check("t3_ready1_next", 32'(req1_ready), 32'h1);
        check("t3_ready0_next", 32'(req0_ready), 32'h0);
        step();                                   // accept req1
        req1_valid = 1'b0;
        div_out    = 1'b0;
        check("t3_busy1", 32'(busy), 32'h1);
        step();
        div_out = 1'b1;
        step();
        check("t3_div_n_10", 32'(div_n), 32'hA);
        step();
        step();
        check("t3_done1",    32'(done),    32'h1);
        check("t3_done_id1", 32'(done_id), 32'h1);
        req0_valid = 1'b1;
        req0_n     = 16'd7;
        req1_valid = 1'b1;
        req1_n     = 16'd8;
        #1;
        check("t3_tie2_ready0", 32'(req0_ready), 32'h1);
        check("t3_tie2_ready1", 32'(req1_ready), 32'h0);
        req0_valid = 1'b0;                        // withdrawn before the edge
        req1_valid = 1'b0;
        step();
        check("t3_withdraw_busy", 32'(busy), 32'h0);

        // 5: request the ratio already in use (10). The request completes
        // with no reset pulse.
        req1_valid = 1'b1;
        req1_n     = 16'd10;
        #1;
        check("t5_ready1", 32'(req1_ready), 32'h1);
        step();
        check("t5_done",      32'(done),       32'h1);
        check("t5_done_id",   32'(done_id),    32'h1);
        check("t5_div_reset", 32'(div_reset),  32'h0);
        check("t5_busy",      32'(busy),       32'h0);
        check("t5_no_ready",  32'(req1_ready), 32'h0);
        req1_valid = 1'b0;
        step();
        check("t5_done_off",   32'(done),      32'h0);
        check("t5_div_reset2", 32'(div_reset), 32'h0);
        check("t5_busy2",      32'(busy),      32'h0);

        // 4: div_out held low, n=3. div_reset rises 10 cycles after accept.
        div_out = 1'b0;
        step();
        req0_valid = 1'b1;
        req0_n     = 16'd3;
        #1;
        check("t4_ready0", 32'(req0_ready), 32'h1);
        step();                                   // accept
        req0_valid = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            step();
            check("t4_wait_div_reset", 32'(div_reset), 32'h0);
        end
        step();
        check("t4_div_reset", 32'(div_reset), 32'h1);
        check("t4_div_n",     32'(div_n),     32'h3);
        step();
        step();
        check("t4_done",      32'(done),      32'h1);
        check("t4_timed_out", 32'(timed_out), 32'h1);
        check("t4_done_id",   32'(done_id),   32'h0);
        step();
        check("t4_timed_out_off", 32'(timed_out), 32'h0);
        check("t4_done_off",      32'(done),      32'h0);

        // 6: reset arrives during HOLD of an n=10 change. req1 stays valid.
        req1_valid = 1'b1;
        req1_n     = 16'd10;
        #1;
        check("t6_ready1", 32'(req1_ready), 32'h1);
        step();                                   // accept
        div_out = 1'b1;
        step();
        check("t6_hold_div_n", 32'(div_n),     32'hA);
        check("t6_hold_reset", 32'(div_reset), 32'h1);
        reset = 1'b1;
        #1;
        check("t6_rst_div_n",  32'(div_n),      32'h0);
        check("t6_rst_dreset", 32'(div_reset),  32'h1);
        check("t6_rst_busy",   32'(busy),       32'h1);
        check("t6_rst_done",   32'(done),       32'h0);
        check("t6_rst_ready1", 32'(req1_ready), 32'h0);
        step();
        reset = 1'b0;
        step();
        check("t6_init_done",   32'(done),       32'h0);
        check("t6_init_dreset", 32'(div_reset),  32'h1);
        check("t6_init_ready1", 32'(req1_ready), 32'h0);
        step();
        check("t6_exit_done",   32'(done),      32'h0);
        check("t6_exit_dreset", 32'(div_reset), 32'h0);
        check("t6_exit_busy",   32'(busy),      32'h0);
        #1;
        check("t6_reaccept_ready1", 32'(req1_ready), 32'h1);
        step();                                   // re-accept
        req1_valid = 1'b0;
        check("t6_busy", 32'(busy), 32'h1);
        div_out = 1'b0;
        step();
        div_out = 1'b1;
        step();
        check("t6_div_n_10",  32'(div_n),     32'hA);
        check("t6_div_reset", 32'(div_reset), 32'h1);
        step();
        step();
        check("t6_done",    32'(done),    32'h1);
        check("t6_done_id", 32'(done_id), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
